// File: rtl/md_pkg.sv
// md_pkg: op codes, queue entry type and defaults shared by the issue queue and multiply/divide unit
package md_pkg;

    localparam int MD_DEPTH = 2;

    typedef enum logic [2:0] {
        OP_NONE  = 3'b000,
        OP_MULT  = 3'b001,
        OP_MULTU = 3'b010,
        OP_DIV   = 3'b011,
        OP_DIVU  = 3'b100,
        OP_MTHI  = 3'b101,
        OP_MTLO  = 3'b110
    } md_op_e;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } md_entry_t;

    function automatic logic is_md_op(input logic [2:0] op);
        return op >= OP_MULT && op <= OP_MTLO;
    endfunction

    function automatic logic is_arith_op(input logic [2:0] op);
        return op >= OP_MULT && op <= OP_DIVU;
    endfunction

endpackage

// File: rtl/md_issue_queue_if.sv
// md_issue_queue_if: E-stage request side and multiply/divide unit side of the issue queue
interface md_issue_queue_if;
    logic        in_valid;
    logic [2:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_ready;
    logic        rd_req;
    logic        rd_stall;
    logic        md_busy;
    logic        md_start;
    logic [2:0]  md_way;
    logic [31:0] md_w1;
    logic [31:0] md_w2;
    logic        md_HIw;
    logic        md_LOw;

    modport master (
        output in_valid, in_op, in_a, in_b, rd_req, md_busy,
        input  in_ready, rd_stall, md_start, md_way, md_w1, md_w2, md_HIw, md_LOw
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, rd_req, md_busy,
        output in_ready, rd_stall, md_start, md_way, md_w1, md_w2, md_HIw, md_LOw
    );
endinterface

// File: rtl/md_fifo.sv
// md_fifo: entry storage with wrapping pointers and occupancy count
module md_fifo
    import md_pkg::*;
#(
    parameter int DEPTH = MD_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  md_entry_t              i_data,
    output md_entry_t              o_head,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);

    md_entry_t      r_mem [DEPTH];
    logic [AW-1:0]  r_wr;
    logic [AW-1:0]  r_rd;
    logic [AW:0]    r_count;
    logic           w_push;
    logic           w_pop;

    assign w_push  = i_push && r_count != (AW+1)'(DEPTH);
    assign w_pop   = i_pop && r_count != '0;
    assign o_head  = r_mem[r_rd];
    assign o_count = r_count;

    // store pushed entry at the write pointer
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end

    // pointers wrap naturally at DEPTH; count tracks push minus pop
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop) r_rd <= r_rd + AW'(1);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
endmodule

// File: rtl/md_issue_queue.sv
// md_issue_queue: buffers mult/div/mthi/mtlo ops and issues them one at a time to the multiply/divide unit
module md_issue_queue
    import md_pkg::*;
#(
    parameter int DEPTH = MD_DEPTH
) (
    input logic             clk,
    input logic             reset,
    md_issue_queue_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0] w_count;
    md_entry_t     w_head;
    md_entry_t     w_in;
    logic          w_push;
    logic          w_issue;
    logic          w_arith;
    logic          r_issued_last;

    assign w_in    = '{op: bus.in_op, a: bus.in_a, b: bus.in_b};
    assign w_push  = bus.in_valid && bus.in_ready && is_md_op(bus.in_op);
    assign w_issue = w_count != '0 && !bus.md_busy && !r_issued_last;
    assign w_arith = is_arith_op(w_head.op);

    md_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_issue),
        .i_data  (w_in),
        .o_head  (w_head),
        .o_count (w_count)
    );

    // busy from the unit lags its start by a cycle; block issue during that gap
    always_ff @(posedge clk) begin
        if (!reset) r_issued_last <= 1'b0;
        else r_issued_last <= w_issue;
    end

    // issue strobes and operands straight from the head entry, zero when idle
    always_comb begin
        bus.in_ready = w_count != CW'(DEPTH);
        bus.rd_stall = bus.rd_req && (w_count != '0 || bus.md_busy || r_issued_last);
        bus.md_start = w_issue && w_arith;
        bus.md_way   = (w_issue && w_arith) ? w_head.op : 3'b000;
        bus.md_HIw   = w_issue && w_head.op == OP_MTHI;
        bus.md_LOw   = w_issue && w_head.op == OP_MTLO;
        bus.md_w1    = w_issue ? w_head.a : 32'd0;
        bus.md_w2    = (w_issue && w_arith) ? w_head.b : 32'd0;
    end
endmodule

// File: tb/tb_md_issue_queue.sv
// tb_md_issue_queue: directed scenarios plus random traffic checked against a queue-based reference model
module tb_md_issue_queue;
    localparam int DEPTH = 2;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } ent_t;

    logic clk = 1'b0;
    logic reset;
    md_issue_queue_if bus();

    md_issue_queue #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    ent_t        mq[$];
    logic        m_il = 1'b0;
    int          n_pass = 0;
    int          n_tot = 0;
    bit          auto_busy = 1'b0;
    int          busy_len = 0;
    int          bcnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    endtask

    // one clock cycle: drive, check mid-cycle against the model, advance the model, cross the edge
    task automatic step(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic rd, input logic bsy, input logic rst);
        logic busy, rdy, iss, start;
        ent_t h;
        busy = auto_busy ? (bcnt != 0) : bsy;
        bus.in_valid = v;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.rd_req   = rd;
        bus.md_busy  = busy;
        reset        = rst;
        #4;
        rdy   = mq.size() != DEPTH;
        iss   = mq.size() != 0 && !busy && !m_il;
        h     = iss ? mq[0] : '{op: 3'd0, a: 32'd0, b: 32'd0};
        start = iss && h.op >= 3'd1 && h.op <= 3'd4;
        chk("in_ready", 32'(bus.in_ready), 32'(rdy));
        chk("rd_stall", 32'(bus.rd_stall), 32'(rd && (mq.size() != 0 || busy || m_il)));
        chk("md_start", 32'(bus.md_start), 32'(start));
        chk("md_way", 32'(bus.md_way), start ? 32'(h.op) : 32'd0);
        chk("md_HIw", 32'(bus.md_HIw), 32'(iss && h.op == 3'd5));
        chk("md_LOw", 32'(bus.md_LOw), 32'(iss && h.op == 3'd6));
        chk("md_w1", bus.md_w1, iss ? h.a : 32'd0);
        chk("md_w2", bus.md_w2, start ? h.b : 32'd0);
        if (!rst) begin
            mq.delete();
            m_il = 1'b0;
        end else begin
            if (iss) void'(mq.pop_front());
            if (v && rdy && op >= 3'd1 && op <= 3'd6) mq.push_back('{op: op, a: a, b: b});
            m_il = iss;
        end
        if (start) bcnt = busy_len;
        else if (bcnt != 0) bcnt--;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic rd, input logic bsy);
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, 32'd0, 32'd0, rd, bsy, 1'b1);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_op    = 3'd0;
        bus.in_a     = 32'd0;
        bus.in_b     = 32'd0;
        bus.rd_req   = 1'b0;
        bus.md_busy  = 1'b0;
        reset        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // reset state: ready, no strobes, stall follows busy only
        step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
        // mult 3 * -2, issued the next cycle, nothing after
        step(1'b1, 3'd1, 32'd3, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1);
        idle(3, 1'b0, 1'b0);
        // div then mtlo with a 10-cycle busy unit
        auto_busy = 1'b1;
        busy_len  = 10;
        step(1'b1, 3'd3, 32'd100, 32'd7, 1'b0, 1'b0, 1'b1);
        step(1'b1, 3'd6, 32'd7, 32'd0, 1'b0, 1'b0, 1'b1);
        idle(14, 1'b0, 1'b0);
        auto_busy = 1'b0;
        // fill while busy, third push rejected, then drain in order
        step(1'b1, 3'd2, 32'hAAAA_0001, 32'h5555_0001, 1'b0, 1'b1, 1'b1);
        step(1'b1, 3'd5, 32'hAAAA_0002, 32'h5555_0002, 1'b0, 1'b1, 1'b1);
        step(1'b1, 3'd4, 32'hAAAA_0003, 32'h5555_0003, 1'b0, 1'b1, 1'b1);
        idle(5, 1'b1, 1'b0);
        // read stall with a single queued entry
        step(1'b1, 3'd1, 32'd9, 32'd9, 1'b1, 1'b1, 1'b1);
        idle(2, 1'b1, 1'b1);
        idle(4, 1'b1, 1'b0);
        // reset discards queued ops while the unit is busy
        step(1'b1, 3'd1, 32'd1, 32'd1, 1'b0, 1'b1, 1'b1);
        step(1'b1, 3'd2, 32'd2, 32'd2, 1'b0, 1'b1, 1'b1);
        step(1'b1, 3'd3, 32'd3, 32'd3, 1'b1, 1'b1, 1'b0);
        idle(4, 1'b1, 1'b0);
        // undefined op code is swallowed
        step(1'b1, 3'd7, 32'd5, 32'd5, 1'b0, 1'b0, 1'b1);
        step(1'b1, 3'd0, 32'd5, 32'd5, 1'b0, 1'b0, 1'b1);
        idle(2, 1'b0, 1'b0);
        // random traffic, alternating between a modelled unit and free-running busy
        for (int i = 0; i < 600; i++) begin
            if (i % 150 == 0) begin
                auto_busy = (i / 150) % 2 == 0;
                busy_len  = int'($urandom_range(0, 4));
            end
            step($urandom_range(0, 9) < 6, 3'($urandom_range(0, 7)), $urandom, $urandom,
                 1'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 39) != 0);
        end
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/md_issue_queue.md
MD_ISSUE_QUEUE -- requirements
Module: md_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning queue entries (power of two, >=2).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset; one clock, reset sampled only on the rising edge of clk.
REQ-004 SHALL have port in_valid  input  1  E-stage presents a mult/div/mthi/mtlo op.
REQ-005 SHALL have port in_op  input  3  op code: 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo.
REQ-006 SHALL have port in_a  input  32  rs operand.
REQ-007 SHALL have port in_b  input  32  rt operand.
REQ-008 SHALL have port in_ready  output  1  queue can accept this cycle.
REQ-009 SHALL have port rd_req  input  1  mfhi/mflo present in E-stage.
REQ-010 SHALL have port rd_stall  output  1  hold pipeline; HI/LO not yet final.
REQ-011 SHALL have port md_busy  input  1  busy from downstream multiply/divide unit.
REQ-012 SHALL have port md_start  output  1  start pulse to multiply/divide unit.
REQ-013 SHALL have port md_way  output  3  op code to unit (001-100, else 000).
REQ-014 SHALL have port md_w1  output  32  first operand / mthi-mtlo data.
REQ-015 SHALL have port md_w2  output  32  second operand.
REQ-016 SHALL have ports md_HIw and md_LOw  output  1 each  HI/LO direct-write strobes.

Function
REQ-017 SHALL push {in_op,in_a,in_b} when in_valid && in_ready && in_op in 001..110; other codes are accepted and discarded.
REQ-018 SHALL drive in_ready = (count != DEPTH); no push when full, even if a pop occurs that cycle.
REQ-019 SHALL issue the head entry in cycle t iff count != 0, md_busy == 0 and issued_last == 0; issue pops the head.
REQ-020 SHALL set issued_last to 1 in the cycle after an issue and 0 otherwise, covering the one cycle before md_busy rises.
REQ-021 SHALL, on issuing ops 001-100, drive md_start=1, md_way=op, md_w1=a, md_w2=b; on 101 drive md_HIw=1, md_w1=a; on 110 drive md_LOw=1, md_w1=a.
REQ-022 SHALL drive md_start, md_HIw, md_LOw, md_way to 0, and md_w1, md_w2 to 0, in any cycle without an issue; at most one strobe SHALL be high per cycle.
REQ-023 SHALL drive issue outputs combinationally from registered queue state and md_busy; minimum latency from push to issue is 1 cycle (no bypass).
REQ-024 SHALL drive rd_stall = rd_req && (count != 0 || md_busy || issued_last).
REQ-025 SHALL preserve strict FIFO order; a simultaneous push and pop SHALL leave count unchanged.
REQ-026 SHALL wrap read and write pointers modulo DEPTH; count range 0..DEPTH.

Reset
REQ-027 SHALL, when reset==0 at a clock edge, clear count, both pointers and issued_last, which discards any queued ops, including during an in-flight operation.
REQ-028 SHALL, after reset, drive in_ready=1, md_start=md_HIw=md_LOw=0, md_way=0, md_w1=md_w2=0, and rd_stall=rd_req&&md_busy.
REQ-029 SHALL treat reset==0 as overriding in_valid in the same cycle: no push occurs.

Structure
REQ-030 SHALL place op-code constants (OP_MULT..OP_MTLO) and DEPTH default in shared package md_pkg, also used by the multiply/divide unit.
REQ-031 SHALL instantiate one sub-module md_fifo (storage, pointers, count); issue/stall logic stays in md_issue_queue.

Verification
REQ-032 Scenario: push mult a=3, b=-2 at t0 with md_busy=0 -> md_start=1, md_way=001, md_w1=3, md_w2=0xFFFFFFFE at t1; no issue at t2.
REQ-033 Scenario: push div then mtlo a=7 back-to-back; model busy for 10 cycles -> mtlo is issued (md_LOw=1, md_w1=7) only in the first cycle with md_busy=0 after div, never while busy.
REQ-034 Scenario: fill with 2 ops while md_busy=1 -> in_ready=0; third in_valid ignored; order of issue is preserved.
REQ-035 Scenario: rd_req=1 with count=1 -> rd_stall=1 until count=0, md_busy=0 and issued_last=0, then 0 in the same cycle.
REQ-036 Scenario: reset=0 with 2 entries queued and md_busy=1 -> next cycle count=0, in_ready=1, no issue after md_busy falls.
REQ-037 Scenario: in_op=111 with in_valid=1 -> in_ready stays 1, count unchanged, no strobe.
